neuron_nvs_lif: RTL and testbench

Parametrised leaky integrate-and-fire neuron. It generalises the fixed 8-synapse neuron to p_inputs synapses and runs on one base clock. The separate level clock is replaced by an internal leak prescaler, and the block adds a refractory period, saturating arithmetic and a wrapping spike counter. It sits between the event/synapse layer and the output spike fabric of the tiny SNN array.

---
 rtl/neuron_nvs_lif.sv | 134 +++++++++++++
 tb/tb_neuron_nvs_lif.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_nvs_lif.sv
// neuron_nvs_lif: parametrised leaky integrate-and-fire neuron.
//
// Each event input passes through a two-flop synchroniser. A rising edge on
// a synchronised input adds that synapse's weight to the membrane potential.
// An internal prescaler generates a periodic leak tick, and the leak is
// subtracted on that tick. The potential saturates at 0 and at
// 2^p_vwidth-1. When the potential reaches a non-zero threshold, the neuron
// fires a one-cycle spike, clears the potential, and then ignores input for
// p_refrac cycles.
//
// Ports:
//   i_base_clk     single clock, rising edge
//   i_rst_n        synchronous active-low reset
//   i_event        asynchronous event pulses, one bit per synapse
//   i_weight       packed weights, synapse k at [k*p_width +: p_width]
//   i_threshold    firing threshold, 0 disables firing
//   i_leak         amount subtracted per leak tick
//   o_syncout      synchronised event levels
//   o_sv           membrane potential
//   o_spike        one-cycle spike pulse
//   o_refrac       high while refractory
//   o_spike_count  wrapping count of spikes since reset
module neuron_nvs_lif #(
    parameter int p_inputs      = 8,
    parameter int p_width       = 8,
    parameter int p_vwidth      = 16,
    parameter int p_leak_period = 16,
    parameter int p_refrac      = 4,
    parameter int p_spike_num   = 2
) (
    input  logic                        i_base_clk,
    input  logic                        i_rst_n,
    input  logic [p_inputs-1:0]         i_event,
    input  logic [p_inputs*p_width-1:0] i_weight,
    input  logic [p_vwidth-1:0]         i_threshold,
    input  logic [p_width-1:0]          i_leak,
    output logic [p_inputs-1:0]         o_syncout,
    output logic [p_vwidth-1:0]         o_sv,
    output logic                        o_spike,
    output logic                        o_refrac,
    output logic [p_spike_num-1:0]      o_spike_count
);

    // The extended width holds the largest positive sum without overflow.
    // The top bit therefore works as a sign flag after the leak is subtracted.
    localparam int EW = p_vwidth + $clog2(p_inputs) + 1;
    localparam int PW = (p_leak_period > 1) ? $clog2(p_leak_period) : 1;
    localparam int RW = (p_refrac > 1) ? $clog2(p_refrac) : 1;

    typedef enum logic {INTEGRATE, REFRAC} state_t;

    state_t                state;
    logic [p_inputs-1:0]   s1, s2, s3;
    logic [p_inputs-1:0]   edges;
    logic [PW-1:0]         presc;
    logic [RW-1:0]         rcnt;
    logic                  leak_tick;
    logic [EW-1:0]         sum;
    logic [EW-1:0]         nv;
    logic [EW-1:0]         vmax;
    logic [p_vwidth-1:0]   clamped;
    logic                  fire;

    assign o_syncout = s2;
    assign edges     = s2 & ~s3;
    assign leak_tick = (presc == PW'(p_leak_period - 1));
    assign vmax      = EW'({p_vwidth{1'b1}});

    always_comb begin
        sum = '0;
        for (int k = 0; k < p_inputs; k++) begin
            if (edges[k])
                sum = sum + EW'(i_weight[k*p_width +: p_width]);
        end
        nv = EW'(o_sv) + sum - (leak_tick ? EW'(i_leak) : EW'(0));
        // Top bit set means the result is negative, so clamp to zero.
        if (nv[EW-1])
            clamped = '0;
        else if (nv > vmax)
            clamped = {p_vwidth{1'b1}};
        else
            clamped = nv[p_vwidth-1:0];
        fire = (i_threshold != '0) && (clamped >= i_threshold);
    end

    always_ff @(posedge i_base_clk) begin
        if (!i_rst_n) begin
            s1            <= '0;
            s2            <= '0;
            s3            <= '0;
            presc         <= '0;
            rcnt          <= '0;
            state         <= INTEGRATE;
            o_sv          <= '0;
            o_spike       <= 1'b0;
            o_refrac      <= 1'b0;
            o_spike_count <= '0;
        end else begin
            s1    <= i_event;
            s2    <= s1;
            s3    <= s2;
            presc <= leak_tick ? '0 : presc + PW'(1);
            case (state)
                INTEGRATE: begin
                    if (fire) begin
                        o_sv          <= '0;
                        o_spike       <= 1'b1;
                        o_spike_count <= o_spike_count + (p_spike_num)'(1);
                        if (p_refrac > 0) begin
                            state    <= REFRAC;
                            rcnt     <= RW'(p_refrac - 1);
                            o_refrac <= 1'b1;
                        end
                    end else begin
                        o_sv    <= clamped;
                        o_spike <= 1'b0;
                    end
                end
                REFRAC: begin
                    // Edges and leak are ignored here, and o_sv stays at 0.
                    o_spike <= 1'b0;
                    if (rcnt == '0) begin
                        state    <= INTEGRATE;
                        o_refrac <= 1'b0;
                    end else begin
                        rcnt <= rcnt - RW'(1);
                    end
                end
                default: state <= INTEGRATE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_nvs_lif.sv
module tb_neuron_nvs_lif;

    localparam int NI = 8;
    localparam int W  = 8;
    localparam int VW = 16;
    localparam int LP = 16;
    localparam int RF = 4;
    localparam int SN = 2;
    localparam int VMAX = (1 << VW) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NI-1:0]     event_in;
    logic [NI*W-1:0]   weight;
    logic [VW-1:0]     threshold;
    logic [W-1:0]      leak;
    logic [NI-1:0]     syncout;
    logic [VW-1:0]     sv;
    logic              spike;
    logic              refrac;
    logic [SN-1:0]     spike_count;

    int tests  = 0;
    int failed = 0;
    bit done   = 1'b0;

    always #5 clk = ~clk;

    neuron_nvs_lif #(
        .p_inputs(NI), .p_width(W), .p_vwidth(VW),
        .p_leak_period(LP), .p_refrac(RF), .p_spike_num(SN)
    ) dut (
        .i_base_clk(clk), .i_rst_n(rst_n), .i_event(event_in),
        .i_weight(weight), .i_threshold(threshold), .i_leak(leak),
        .o_syncout(syncout), .o_sv(sv), .o_spike(spike),
        .o_refrac(refrac), .o_spike_count(spike_count)
    );

    typedef struct {
        int sync;
        int v;
        int spk;
        int rfr;
        int cnt;
    } exp_t;

    exp_t exp_q[$];

    int hist[3];
    int m_v, m_cycle, m_skip, m_cnt, m_spk;

    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hist = '{0, 0, 0};
            m_v = 0; m_cycle = 0; m_skip = 0; m_cnt = 0; m_spk = 0;
        end else begin
            int rise, add, nv;
            rise = hist[1] & ~hist[2];
            if (m_skip > 0) begin
                m_skip--;
                m_spk = 0;
            end else begin
                add = 0;
                for (int k = 0; k < NI; k++)
                    if (rise[k]) add += int'(weight[k*W +: W]);
                nv = m_v + add;
                if ((m_cycle % LP) == LP - 1) nv -= int'(leak);
                if (nv < 0) nv = 0;
                if (nv > VMAX) nv = VMAX;
                if (threshold != 0 && nv >= int'(threshold)) begin
                    m_v = 0; m_spk = 1; m_cnt = (m_cnt + 1) % (1 << SN);
                    m_skip = RF;
                end else begin
                    m_v = nv; m_spk = 0;
                end
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = int'(event_in);
            m_cycle++;
        end
        e.sync = hist[1]; e.v = m_v; e.spk = m_spk;
        e.rfr = (m_skip > 0) ? 1 : 0; e.cnt = m_cnt;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests++;
            if (int'(syncout) != e.sync || int'(sv) != e.v || int'(spike) != e.spk ||
                int'(refrac) != e.rfr || int'(spike_count) != e.cnt) begin
                failed++;
                $display("FAIL outputs t=%0t: got sync=%h sv=%h spk=%0d rfr=%0d cnt=%0d want sync=%h sv=%h spk=%0d rfr=%0d cnt=%0d",
                         $time, syncout, sv, spike, refrac, spike_count,
                         e.sync, e.v, e.spk, e.rfr, e.cnt);
            end
        end
    end

    initial begin
        #2000000;
        if (!done) begin
            failed++;
            $display("FAIL timeout: stimulus did not complete, %0d tests run", tests);
            $finish;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [NI-1:0] ev, input int gap);
        event_in = ev;
        wait_cyc(1);
        event_in = '0;
        wait_cyc(gap);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        tests++;
        if (syncout != '0 || sv != '0 || spike != 1'b0 || refrac != 1'b0 ||
            spike_count != '0) begin
            failed++;
            $display("FAIL %s t=%0t: sync=%h sv=%h spk=%0d rfr=%0d cnt=%0d",
                     tag, $time, syncout, sv, spike, refrac, spike_count);
        end
    endtask

    initial begin
        rst_n = 1'b0; event_in = '0; weight = {NI{8'hFF}};
        threshold = 16'h03FF; leak = '0;
        wait_cyc(3);
        check_zero("reset state");
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) pulse(NI'(1 << k), 9);
        wait_cyc(5);

        do_reset(); threshold = '0;
        pulse(8'h42, 5); pulse(8'h24, 5); pulse(8'h18, 5);

        for (int i = 0; i < 40; i++) begin
            event_in = 8'hFF; wait_cyc(2);
            event_in = 8'h00; wait_cyc(2);
        end

        do_reset(); weight = '0; weight[7:0] = 8'h80; weight[15:8] = 8'h80;
        pulse(8'h03, 4);
        leak = 8'h10;
        wait_cyc(400);
        leak = '0;

        do_reset(); weight = {NI{8'hFF}}; threshold = 16'h0100;
        for (int s = 0; s < 4; s++) begin
            pulse(8'h03, 0);
            wait_cyc(1);
            pulse(8'h04, 3);
            pulse(8'h08, 8);
        end

        pulse(8'h03, 2);
        event_in = 8'h10;
        rst_n = 1'b0; wait_cyc(1);
        check_zero("reset in refractory");
        rst_n = 1'b1; event_in = '0;
        wait_cyc(6);

        for (int i = 0; i < 3000; i++) begin
            logic [NI-1:0] ev;
            ev = '0;
            for (int k = 0; k < NI; k++) ev[k] = ($urandom_range(0, 5) == 0);
            event_in = ev;
            if ($urandom_range(0, 50) == 0) weight = {$urandom, $urandom};
            if ($urandom_range(0, 100) == 0)
                case ($urandom_range(0, 3))
                    0: threshold = '0;
                    1: threshold = 16'(($urandom_range(1, 1023)));
                    2: threshold = 16'hFFFF;
                    default: threshold = 16'($urandom);
                endcase
            if ($urandom_range(0, 60) == 0) leak = 8'($urandom_range(0, 40));
            rst_n = ($urandom_range(0, 300) != 0);
            wait_cyc(1);
        end
        rst_n = 1'b1; event_in = '0;
        wait_cyc(3);

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
